alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester, round-robin arbiter that time-shares the single 64-bit carry-flag ALU of the execute stage. The two clients are the integer execute path (port 0) and the branch/compare unit (port 1). Each request carries operands and a 4-bit ALU control code. The block drives the external combinational ALU for the granted request, registers the result and flags into a per-requester response slot, and holds them until the requester takes them. Invalid control codes are flagged, not executed.

## Interface
- DATA_W, 64, operand/result width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle when valid&ready
- req_a  in  2*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
- req_b  in  2*DATA_W  operand B, same packing
- req_op  in  8  ALU control, requester i at [i*4 +: 4]
- rsp_valid  out  2  response slot i holds a result
- rsp_ready  in  2  requester i consumes its response
- rsp_result  out  2*DATA_W  registered result, packed like req_a
- rsp_zero, rsp_negative, rsp_carry, rsp_err  out  2 each  registered flags per slot
- alu_a, alu_b  out  DATA_W  operands to the shared ALU
- alu_ctrl  out  4  control to the shared ALU
- alu_result  in  DATA_W  combinational ALU result
- alu_zero, alu_negative, alu_carry  in  1  combinational ALU flags

## Operation
- Supported codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 EOR
  - Any other code is illegal.
- Slot i is free when rsp_valid[i]=0, or when rsp_valid[i]=1 and rsp_ready[i]=1 in the same cycle (drain-and-refill).
- Requester i is eligible when req_valid[i]=1 and slot i is free.
- Arbitration:
  - One grant per cycle at most.
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the one not in register last_grant is granted.
  - last_grant updates to the granted index only on a grant. Its reset value is 1, so requester 0 wins the first contention.
- req_ready[i] = grant[i]. This is combinational from req_valid, rsp_valid, rsp_ready and last_grant. req_ready never asserts without req_valid.
- ALU drive:
  - With a grant, alu_a, alu_b and alu_ctrl carry the granted request's fields.
  - With no grant, all three are 0.
  - For an illegal op, alu_ctrl is still driven, but the ALU outputs are ignored.
- Capture on a grant to slot i:
  - Legal op: rsp_result[i] is loaded from alu_result, and the zero/negative/carry flags from the ALU. rsp_err[i]=0.
  - Illegal op: rsp_result[i]=0, rsp_zero[i]=1, rsp_negative[i]=0, rsp_carry[i]=0, rsp_err[i]=1.
- ALU contract that the bench models:
  - ADD carry = carry-out of the DATA_W-bit sum.
  - SUB is computed as A+~B+1, and carry is its carry-out (1 means no borrow).
  - Logic ops have carry=0.
  - negative = result MSB; zero = (result==0).
- Slot i with no grant: if rsp_ready[i]=1, rsp_valid[i] clears; otherwise all slot registers hold.

## Timing
- Reset (asynchronous, takes effect immediately):
  - rsp_valid=00.
  - All rsp_result, rsp_zero, rsp_negative, rsp_carry and rsp_err bits = 0.
  - last_grant=1.
  - The combinational outputs follow from rsp_valid=00.
- Latency: a request accepted at edge N shows rsp_valid=1 with data from edge N (i.e. in cycle N+1).
- Throughput: 1 op per cycle in total. Each requester can sustain 1 op per cycle while its rsp_ready=1 and the other requester is idle.
- Response stability: while rsp_valid[i]=1 and rsp_ready[i]=0, every slot-i output is stable.
- Backpressure: requester i is never granted while slot i is full and not draining. In that case the other requester may be granted in the same cycle.
- Reset mid-operation: in-flight responses are discarded and no stale rsp_valid survives. The first grant after reset obeys last_grant=1.

## Test plan
- Single ADD on port 0, A=0xF, B=0xA, op=0010, rsp_ready=1:
  - req_ready[0]=1 in the same cycle.
  - Next cycle: rsp_valid[0]=1, result=0x19, zero=0, neg=0, carry=0, err=0.
- Port 1 operations:
  - ADD with A=B=0xFFFFFFFF: result=0x1FFFFFFFE, carry=0.
  - SUB 5−10: result=0xFFFFFFFFFFFFFFFB, neg=1, carry=0.
  - SUB 10−10: result=0, zero=1, carry=1.
- Contention, both ports valid every cycle with rsp_ready=11 after reset:
  - Grants go 0,1,0,1.
  - Port 0 sees OR 0xF|0xA=0xF; port 1 sees AND 0xF&0xA=0xA; EOR gives 0x5.
- Backpressure on port 0:
  - rsp_ready[0]=0 for 3 cycles: req_ready[0]=0 and slot 0 is stable, while port 1 is granted every cycle.
  - Raising rsp_ready[0] with req_valid[0]=1 drains and refills slot 0 in one cycle.
- Illegal op 0101 on port 1:
  - rsp_err[1]=1, result=0, zero=1.
  - The next legal op on port 1 clears err.
- Assert reset while rsp_valid=11 and both ports are requesting:
  - Outputs clear immediately.
  - After release, with contention, port 0 is granted first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters,
// with a registered response slot per requester that holds until it is consumed.
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [7:0]          req_op,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [2*DATA_W-1:0] rsp_result,
    output logic [1:0]          rsp_zero,
    output logic [1:0]          rsp_negative,
    output logic [1:0]          rsp_carry,
    output logic [1:0]          rsp_err,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [3:0]          alu_ctrl,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    input  logic                alu_negative,
    input  logic                alu_carry
);

    localparam int unsigned N_REQ = 2;
    localparam int unsigned OP_W  = 4;

    logic [N_REQ-1:0]        w_slot_free;
    logic [N_REQ-1:0]        w_elig;
    logic [N_REQ-1:0]        w_grant;
    logic                    w_any;
    logic                    w_sel;
    logic                    w_legal;

    logic                    r_last_grant;
    logic [N_REQ-1:0]        r_rsp_valid;
    logic [N_REQ*DATA_W-1:0] r_rsp_result;
    logic [N_REQ-1:0]        r_rsp_zero;
    logic [N_REQ-1:0]        r_rsp_negative;
    logic [N_REQ-1:0]        r_rsp_carry;
    logic [N_REQ-1:0]        r_rsp_err;

    // A slot may accept a new result when empty or being drained this cycle.
    always_comb begin
        w_slot_free = ~r_rsp_valid | rsp_ready;
        w_elig      = req_valid & w_slot_free;
        w_grant     = '0;
        case (w_elig)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = '0;
        endcase
        w_any = |w_grant;
        w_sel = w_grant[1];
    end

    assign req_ready = w_grant;

    // ALU operand mux; idle cycles drive zeros.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (w_any) begin
            alu_a    = w_sel ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
            alu_b    = w_sel ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
            alu_ctrl = w_sel ? req_op[OP_W +: OP_W]    : req_op[0 +: OP_W];
        end
    end

    always_comb begin
        w_legal = 1'b0;
        case (alu_ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: w_legal = 1'b1;
            default:                                     w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_any) begin
            r_last_grant <= w_sel;
        end
    end

    // Per-slot capture: grant loads, a consume without grant empties, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid    <= '0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= '0;
            r_rsp_negative <= '0;
            r_rsp_carry    <= '0;
            r_rsp_err      <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (w_grant[i]) begin
                    r_rsp_valid[i] <= 1'b1;
                    if (w_legal) begin
                        r_rsp_result[i*DATA_W +: DATA_W] <= alu_result;
                        r_rsp_zero[i]     <= alu_zero;
                        r_rsp_negative[i] <= alu_negative;
                        r_rsp_carry[i]    <= alu_carry;
                        r_rsp_err[i]      <= 1'b0;
                    end else begin
                        r_rsp_result[i*DATA_W +: DATA_W] <= '0;
                        r_rsp_zero[i]     <= 1'b1;
                        r_rsp_negative[i] <= 1'b0;
                        r_rsp_carry[i]    <= 1'b0;
                        r_rsp_err[i]      <= 1'b1;
                    end
                end else if (rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_negative = r_rsp_negative;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural model of the shared ALU.
module tb_alu_share_arbiter;

    localparam int unsigned DATA_W = 64;

    logic                clk;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [7:0]          req_op;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [2*DATA_W-1:0] rsp_result;
    logic [1:0]          rsp_zero;
    logic [1:0]          rsp_negative;
    logic [1:0]          rsp_carry;
    logic [1:0]          rsp_err;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [3:0]          alu_ctrl;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                alu_negative;
    logic                alu_carry;

    int n_vec;
    int n_miss;

    alu_share_arbiter #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_negative (rsp_negative),
        .rsp_carry    (rsp_carry),
        .rsp_err      (rsp_err),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_carry    (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model: SUB is A + ~B + 1, logic ops clear carry.
    logic [DATA_W:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_ctrl)
            4'b0000: alu_wide = {1'b0, alu_a & alu_b};
            4'b0001: alu_wide = {1'b0, alu_a | alu_b};
            4'b0010: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0110: alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + (DATA_W+1)'(1);
            4'b0111: alu_wide = {1'b0, alu_a ^ alu_b};
            default: alu_wide = {1'b0, {(DATA_W/4){4'hD}}};
        endcase
        alu_result   = alu_wide[DATA_W-1:0];
        alu_carry    = alu_wide[DATA_W];
        alu_zero     = (alu_wide[DATA_W-1:0] == '0);
        alu_negative = alu_wide[DATA_W-1];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] b0,
                         input logic [3:0] op0, input logic [63:0] a1, input logic [63:0] b1,
                         input logic [3:0] op1, input logic [1:0] rdy);
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_op    = {op1, op0};
        rsp_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
    endtask

    logic [63:0] res0;
    logic [63:0] res1;
    assign res0 = rsp_result[63:0];
    assign res1 = rsp_result[127:64];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
        #12;
        check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        check("reset_result", rsp_result, 128'(0));
        check("reset_flags", 128'({rsp_zero, rsp_negative, rsp_carry, rsp_err}), 128'(0));
        check("reset_req_ready", 128'(req_ready), 128'(0));
        check("idle_alu", 128'({alu_ctrl, alu_a}), 128'(0));
        reset = 1'b0;
        tick();

        // Single ADD on port 0
        drive(2'b01, 64'hF, 64'hA, 4'b0010, 0, 0, 0, 2'b11);
        #1;
        check("add0_req_ready", 128'(req_ready), 128'(2'b01));
        check("add0_alu_drive", 128'({alu_ctrl, alu_a, alu_b}), {60'd0, 4'b0010, 64'hF, 64'hA});
        tick();
        check("add0_valid", 128'(rsp_valid), 128'(2'b01));
        check("add0_result", 128'(res0), 128'(64'h19));
        check("add0_flags", 128'({rsp_zero[0], rsp_negative[0], rsp_carry[0], rsp_err[0]}), 128'(0));

        // Port 1 arithmetic
        drive(2'b10, 0, 0, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'b0010, 2'b11);
        tick();
        check("add1_result", 128'(res1), 128'(64'h1_FFFF_FFFE));
        check("add1_carry", 128'(rsp_carry[1]), 128'(0));
        drive(2'b10, 0, 0, 0, 64'd5, 64'd10, 4'b0110, 2'b11);
        tick();
        check("sub_neg_result", 128'(res1), 128'(64'hFFFF_FFFF_FFFF_FFFB));
        check("sub_neg_flags", 128'({rsp_zero[1], rsp_negative[1], rsp_carry[1]}), 128'(3'b010));
        drive(2'b10, 0, 0, 0, 64'd10, 64'd10, 4'b0110, 2'b11);
        tick();
        check("sub_zero_result", 128'(res1), 128'(0));
        check("sub_zero_flags", 128'({rsp_zero[1], rsp_negative[1], rsp_carry[1]}), 128'(3'b101));
        check("port0_drained", 128'(rsp_valid[0]), 128'(0));

        // Contention after reset: grants alternate starting with port 0
        drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
        pulse_reset();
        drive(2'b11, 64'hF, 64'hA, 4'b0001, 64'hF, 64'hA, 4'b0000, 2'b11);
        #1;
        check("cont1_grant", 128'(req_ready), 128'(2'b01));
        tick();
        check("cont1_or", 128'(res0), 128'(64'hF));
        #1;
        check("cont2_grant", 128'(req_ready), 128'(2'b10));
        tick();
        check("cont2_and", 128'(res1), 128'(64'hA));
        drive(2'b11, 64'hF, 64'hA, 4'b0111, 64'hF, 64'hA, 4'b0111, 2'b11);
        #1;
        check("cont3_grant", 128'(req_ready), 128'(2'b01));
        tick();
        check("cont3_eor", 128'(res0), 128'(64'h5));
        #1;
        check("cont4_grant", 128'(req_ready), 128'(2'b10));
        tick();
        check("cont4_eor", 128'(res1), 128'(64'h5));
        check("cont4_valid", 128'(rsp_valid), 128'(2'b10));

        // Backpressure on port 0
        drive(2'b01, 64'd1, 64'd2, 4'b0010, 0, 0, 0, 2'b10);
        tick();
        check("bp_fill", 128'({rsp_valid[0], res0}), {63'd0, 1'b1, 64'd3});
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 64'd9, 64'd9, 4'b0010, 64'(k), 64'd100, 4'b0010, 2'b10);
            #1;
            check("bp_grant", 128'(req_ready), 128'(2'b10));
            tick();
            check("bp_slot0_hold", 128'({rsp_valid[0], rsp_err[0], rsp_zero[0], res0}),
                  {61'd0, 3'b100, 64'd3});
            check("bp_port1", 128'(res1), 128'(64'd100 + 64'(k)));
        end
        drive(2'b01, 64'd7, 64'd1, 4'b0010, 0, 0, 0, 2'b11);
        #1;
        check("bp_refill_grant", 128'(req_ready), 128'(2'b01));
        tick();
        check("bp_refill", 128'({rsp_valid[0], res0}), {63'd0, 1'b1, 64'd8});

        // Illegal op on port 1, then a legal op clears the error
        drive(2'b10, 0, 0, 0, 64'd3, 64'd4, 4'b0101, 2'b11);
        #1;
        check("ill_ctrl", 128'({req_ready, alu_ctrl}), 128'({2'b10, 4'b0101}));
        tick();
        check("ill_result", 128'(res1), 128'(0));
        check("ill_flags", 128'({rsp_valid[1], rsp_err[1], rsp_zero[1], rsp_negative[1], rsp_carry[1]}),
              128'(5'b11100));
        drive(2'b10, 0, 0, 0, 64'd3, 64'd4, 4'b0001, 2'b11);
        tick();
        check("legal_after_ill", 128'({rsp_err[1], rsp_zero[1], res1}), {62'd0, 2'b00, 64'd7});

        // Fill both slots ending with last grant on port 0, then reset mid-stream
        drive(2'b10, 0, 0, 0, 64'd1, 64'd1, 4'b0010, 2'b00);
        tick();
        drive(2'b01, 64'd2, 64'd2, 4'b0010, 0, 0, 0, 2'b00);
        tick();
        check("full_both", 128'(rsp_valid), 128'(2'b11));
        drive(2'b11, 64'd6, 64'd6, 4'b0010, 64'd5, 64'd5, 4'b0010, 2'b00);
        #1;
        check("full_no_grant", 128'(req_ready), 128'(0));
        #1;
        reset = 1'b1;
        #1;
        check("midrst_valid", 128'(rsp_valid), 128'(0));
        check("midrst_result", rsp_result, 128'(0));
        check("midrst_grant", 128'(req_ready), 128'(2'b01));
        reset = 1'b0;
        drive(2'b11, 64'd6, 64'd6, 4'b0010, 64'd5, 64'd5, 4'b0010, 2'b11);
        tick();
        check("post_rst_first", 128'({rsp_valid, res0}), {62'd0, 2'b01, 64'd12});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
